regfile_bank: RTL and testbench
===============================

Name: regfile_bank

Overview:
- Parametrised general-purpose register file for the datapath, next generation of the fixed 12x24-bit, 2R/1W register file.
- Adds configurable width, depth and read-port count, plus write-to-read bypass and an optional hardwired zero register.
- Adds an asynchronous active-low reset, and a multi-cycle clear sequencer that replaces the old clear-on-PC-zero.
- Adds a per-register pending scoreboard so the control unit can stall on outstanding multi-cycle results.

Parameters:
- DATA_W, 24: register width in bits.
- NUM_REGS, 12: number of implemented registers (2..2**ADDR_W).
- ADDR_W, 4: register address width.
- NUM_RD, 2: number of combinational read ports (1..4).
- ZERO_REG, 0: 1 = register 0 always reads 0 and ignores writes and reserves.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- ra, in, NUM_RD*ADDR_W: read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd, out, NUM_RD*DATA_W: read data; port i uses bits [i*DATA_W +: DATA_W].
- pend, out, NUM_RD: pending bit of the register addressed by ra[i].
- we, in, 1: write enable.
- wa, in, ADDR_W: write address.
- wd, in, DATA_W: write data.
- rsv_en, in, 1: mark register rsv_addr pending.
- rsv_addr, in, ADDR_W: register to reserve.
- clr_req, in, 1: start the clear sequence (one-cycle pulse or level).
- busy, out, 1: high while the clear sequence runs.
- wr_err, out, 1: registered one-cycle pulse flagging a dropped write.

Behaviour:
- Reset (rst_n=0, async): all registers 0, all pending bits 0, FSM IDLE, clear counter 0, busy 0, wr_err 0. Deassertion is synchronised externally. Reset mid-clear aborts the sequence and returns to IDLE.
- Write: on the clk rising edge, when we=1, state IDLE, wa<NUM_REGS, and not (ZERO_REG=1 and wa=0), rf[wa]<=wd and pending[wa]<=0.
- Dropped write: a write rejected for any of the reasons below is dropped, and wr_err=1 in the next cycle. Otherwise wr_err=0.
  - state is CLEAR;
  - wa>=NUM_REGS.
- Write to register 0 with ZERO_REG=1 is silently ignored; wr_err stays 0.
- Read (combinational, zero latency), for each port i:
  - ra[i]>=NUM_REGS, or ZERO_REG=1 and ra[i]=0: rd[i]=0, pend[i]=0.
  - Else if we=1 in IDLE and wa==ra[i] is a valid write: rd[i]=wd (bypass).
  - Else rd[i]=rf[ra[i]].
  - pend[i]=pending[ra[i]], taking the same-cycle write/reserve into account. A same-cycle write bypasses pend[i] to 0; a same-cycle reserve to the same address gives pend[i]=1.
- Scoreboard:
  - rsv_en=1 in IDLE with a valid address sets pending[rsv_addr] at the clock edge.
  - Write and reserve to the same register in the same cycle: data is written and pending ends at 1 (reserve wins: a new producer is outstanding).
  - rsv_en during CLEAR or with an invalid address is ignored; no wr_err.
- Clear FSM:
  - IDLE -> CLEAR when clr_req=1: counter<=0, all pending bits <=0 at that edge.
  - In CLEAR, each cycle: rf[counter]<=0 and counter++. Exit to IDLE on the edge where counter==NUM_REGS-1.
  - Sequence takes exactly NUM_REGS cycles; busy=1 for exactly those NUM_REGS cycles (busy is a decode of state).
  - clr_req while in CLEAR is ignored (no restart).
  - Reads during CLEAR return the array contents (partly cleared); the bypass is disabled.
- Width rules: no arithmetic on data; the counter is ADDR_W bits and never wraps past NUM_REGS-1.

Decomposition:
- Shared package regfile_pkg:
  - typedef rf_state_t {RF_IDLE, RF_CLEAR};
  - default DATA_W/NUM_REGS/ADDR_W localparams, shared with the ALU and control unit.
- Sub-module regfile_clr_seq: clear FSM plus counter. Outputs busy, clr_we, clr_addr and clr_start (pending flush).
- The storage array, bypass muxes and scoreboard stay in regfile_bank.

Test Plan:
- Reset then read: rst_n low 2 cycles, release; ra={3,7} -> rd={0,0}, pend=0, busy=0, wr_err=0.
- Write/bypass: we=1, wa=5, wd=24'hABCDEF, ra port0=5 in the same cycle -> rd0=24'hABCDEF combinationally; the next cycle with we=0 still reads 24'hABCDEF.
- Scoreboard: rsv_en, rsv_addr=4 -> pend=1 on reads of 4 next cycle. Later we=1, wa=4, wd=24'h000010 -> pend 0 in the same cycle (bypass) and after.
  - Simultaneous rsv_en and we on 6 -> pend stays 1, data 6 updated.
- Clear: fill regs 0..11 with 24'h111111, pulse clr_req -> busy high exactly 12 cycles, all reads 0 and all pend 0 afterwards.
  - we during busy -> wr_err pulse, no write.
  - A second clr_req mid-sequence -> still 12 cycles.
- Boundaries: wa=12 (NUM_REGS=12) -> wr_err=1 next cycle, rf unchanged; ra=15 -> rd=0.
  - ZERO_REG=1 build: write 24'hFFFFFF to 0 -> rd=0, wr_err=0.
- Async reset mid-clear: assert rst_n=0 at clear cycle 5 without clock edge -> busy=0 immediately, IDLE after release, all registers 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the datapath register file,
// also used by the ALU and control unit.
package regfile_pkg;

    localparam int DATA_W_DEF   = 24;
    localparam int NUM_REGS_DEF = 12;
    localparam int ADDR_W_DEF   = 4;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks a counter over every implemented register, one per cycle,
// and flags the cycle a clear starts so the pending scoreboard can be flushed.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output rf_state_t         state,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_start
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    rf_state_t         state_q;
    logic [ADDR_W-1:0] cnt_q;

    // clr_req is only honoured from IDLE, so a request mid-sequence never restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                RF_IDLE: begin
                    if (clr_req) begin
                        state_q <= RF_CLEAR;
                        cnt_q   <= '0;
                    end
                end
                RF_CLEAR: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= RF_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= RF_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign state     = state_q;
    assign busy      = (state_q == RF_CLEAR);
    assign clr_we    = (state_q == RF_CLEAR);
    assign clr_addr  = cnt_q;
    assign clr_start = (state_q == RF_IDLE) && clr_req;

endmodule

// File: rtl/regfile_bank.sv
// Parametrised multi-read, single-write register file with write-to-read bypass,
// optional hardwired zero register, pending scoreboard and sequenced clear.
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        pend,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     wr_err
);

    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0]   rf [NUM_REGS];
    logic [NUM_REGS-1:0] pending;

    rf_state_t           seq_state;
    logic                clr_we;
    logic [ADDR_W-1:0]   clr_addr;
    logic                clr_start;

    logic                in_idle;
    logic                wr_ok;
    logic                wr_drop;
    logic                rsv_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < REG_LIMIT);
    endfunction

    // Addresses that map to real storage; the hardwired zero register does not.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return in_range(a) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    regfile_clr_seq #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clr_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req),
        .state     (seq_state),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .clr_start (clr_start)
    );

    assign in_idle = (seq_state == RF_IDLE);
    assign wr_ok   = we && in_idle && addr_ok(wa);
    assign wr_drop = we && (!in_idle || !in_range(wa));
    assign rsv_ok  = rsv_en && in_idle && addr_ok(rsv_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (clr_we && (clr_addr == ADDR_W'(i))) begin
                    rf[i] <= '0;
                end else if (wr_ok && (wa == ADDR_W'(i))) begin
                    rf[i] <= wd;
                end
            end
        end
    end

    // Reserve is applied after the write so a new outstanding producer wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (clr_start) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_ok && (wa == ADDR_W'(i))) begin
                    pending[i] <= 1'b0;
                end
                if (rsv_ok && (rsv_addr == ADDR_W'(i))) begin
                    pending[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_drop;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              pbit;

        assign addr = ra[p*ADDR_W +: ADDR_W];

        always_comb begin
            data = '0;
            pbit = 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr == ADDR_W'(i)) begin
                    data = rf[i];
                    pbit = pending[i];
                end
            end
            if (!addr_ok(addr)) begin
                data = '0;
                pbit = 1'b0;
            end else begin
                if (wr_ok && (wa == addr)) begin
                    data = wd;
                    pbit = 1'b0;
                end
                if (rsv_ok && (rsv_addr == addr)) begin
                    pbit = 1'b1;
                end
            end
        end

        assign rd[p*DATA_W +: DATA_W] = data;
        assign pend[p]                = pbit;
    end

endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench for regfile_bank: default build plus a ZERO_REG=1 build
// sharing clock and reset.
module tb_regfile_bank;

    localparam int DW = 24;
    localparam int AW = 4;
    localparam int NR = 12;

    logic          clk;
    logic          rst_n;

    logic [2*AW-1:0] ra;
    logic [2*DW-1:0] rd;
    logic [1:0]      pend;
    logic            we;
    logic [AW-1:0]   wa;
    logic [DW-1:0]   wd;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            clr_req;
    logic            busy;
    logic            wr_err;

    logic [2*AW-1:0] z_ra;
    logic [2*DW-1:0] z_rd;
    logic [1:0]      z_pend;
    logic            z_we;
    logic [AW-1:0]   z_wa;
    logic [DW-1:0]   z_wd;
    logic            z_busy;
    logic            z_wr_err;

    int checks   = 0;
    int failures = 0;
    int busy_cycles;
    logic [DW-1:0] exp_q[$];

    regfile_bank #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(0)) dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .pend(pend),
        .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .busy(busy), .wr_err(wr_err)
    );

    regfile_bank #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .ra(z_ra), .rd(z_rd), .pend(z_pend),
        .we(z_we), .wa(z_wa), .wd(z_wd), .rsv_en(1'b0), .rsv_addr(4'd0),
        .clr_req(1'b0), .busy(z_busy), .wr_err(z_wr_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0};
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1;
        wa = a;
        wd = d;
        next_cycle();
        we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ra = '0; we = 1'b0; wa = '0; wd = '0;
        rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
        z_ra = '0; z_we = 1'b0; z_wa = '0; z_wd = '0;

        // reset then read
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_ra(4'd3, 4'd7);
        @(negedge clk);
        check("rst_rd0", rd[23:0], 24'h0);
        check("rst_rd1", rd[47:24], 24'h0);
        check("rst_pend", pend, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_err", wr_err, 1'b0);

        // write with same-cycle bypass
        next_cycle();
        we = 1'b1; wa = 4'd5; wd = 24'hABCDEF;
        set_ra(4'd5, 4'd3);
        @(negedge clk);
        check("bypass_rd0", rd[23:0], 24'hABCDEF);
        check("bypass_pend0", pend[0], 1'b0);
        next_cycle();
        we = 1'b0;
        @(negedge clk);
        check("stored_rd0", rd[23:0], 24'hABCDEF);
        check("write_no_err", wr_err, 1'b0);

        // reserve, then retire by write
        next_cycle();
        rsv_en = 1'b1; rsv_addr = 4'd4;
        set_ra(4'd4, 4'd5);
        @(negedge clk);
        check("rsv_same_cycle_pend", pend[0], 1'b1);
        next_cycle();
        rsv_en = 1'b0;
        @(negedge clk);
        check("rsv_pend", pend, 2'b01);
        next_cycle();
        we = 1'b1; wa = 4'd4; wd = 24'h000010;
        @(negedge clk);
        check("retire_bypass_pend", pend[0], 1'b0);
        check("retire_bypass_rd", rd[23:0], 24'h000010);
        next_cycle();
        we = 1'b0;
        @(negedge clk);
        check("retire_pend", pend[0], 1'b0);
        check("retire_rd", rd[23:0], 24'h000010);

        // simultaneous write and reserve: reserve wins
        next_cycle();
        we = 1'b1; wa = 4'd6; wd = 24'h123456;
        rsv_en = 1'b1; rsv_addr = 4'd6;
        set_ra(4'd6, 4'd4);
        @(negedge clk);
        check("wr_rsv_comb_pend", pend[0], 1'b1);
        check("wr_rsv_comb_rd", rd[23:0], 24'h123456);
        next_cycle();
        we = 1'b0; rsv_en = 1'b0;
        @(negedge clk);
        check("wr_rsv_pend", pend[0], 1'b1);
        check("wr_rsv_rd", rd[23:0], 24'h123456);

        // out-of-range write and read
        next_cycle();
        we = 1'b1; wa = 4'd12; wd = 24'h777777;
        set_ra(4'd15, 4'd5);
        @(negedge clk);
        check("oor_rd", rd[23:0], 24'h0);
        check("oor_pend", pend[0], 1'b0);
        next_cycle();
        we = 1'b0;
        @(negedge clk);
        check("oor_wr_err", wr_err, 1'b1);
        check("oor_rf_unchanged", rd[47:24], 24'hABCDEF);
        next_cycle();
        @(negedge clk);
        check("oor_wr_err_pulse", wr_err, 1'b0);

        // fill all registers, reserve r11 on its write
        for (int i = 0; i < NR; i++) begin
            we = 1'b1; wa = AW'(i); wd = 24'h111111;
            rsv_en = (i == NR - 1); rsv_addr = 4'd11;
            next_cycle();
        end
        we = 1'b0; rsv_en = 1'b0;
        set_ra(4'd11, 4'd3);
        @(negedge clk);
        check("fill_rd11", rd[23:0], 24'h111111);
        check("fill_pend11", pend[0], 1'b1);

        // clear sequence with dropped write and ignored second request
        next_cycle();
        clr_req = 1'b1;
        next_cycle();
        clr_req = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cycles++;
            if (busy_cycles == 1) begin
                check("clr_pend_flushed", pend[0], 1'b0);
                we = 1'b1; wa = 4'd3; wd = 24'hABABAB;
                #1;
                check("clr_no_bypass", rd[47:24], 24'h111111);
            end
            if (busy_cycles == 2) begin
                we = 1'b0;
                check("clr_wr_err", wr_err, 1'b1);
            end
            if (busy_cycles == 3) check("clr_wr_err_pulse", wr_err, 1'b0);
            if (busy_cycles == 5) clr_req = 1'b1;
            if (busy_cycles == 6) clr_req = 1'b0;
        end
        check("clr_busy_cycles", busy_cycles, NR);

        for (int i = 0; i < NR; i++) exp_q.push_back(24'h0);
        for (int i = 0; i < NR; i++) begin
            set_ra(AW'(i), AW'(i));
            #1;
            check("clr_rd", rd[23:0], exp_q.pop_front());
            check("clr_pend", pend[0], 1'b0);
        end

        // hardwired zero register build
        next_cycle();
        z_we = 1'b1; z_wa = 4'd0; z_wd = 24'hFFFFFF;
        z_ra = {4'd1, 4'd0};
        @(negedge clk);
        check("zero_bypass_rd", z_rd[23:0], 24'h0);
        next_cycle();
        z_wa = 4'd1; z_wd = 24'h5A5A5A;
        @(negedge clk);
        check("zero_rd", z_rd[23:0], 24'h0);
        check("zero_wr_err", z_wr_err, 1'b0);
        next_cycle();
        z_we = 1'b0;
        @(negedge clk);
        check("zero_r1_rd", z_rd[47:24], 24'h5A5A5A);

        // async reset in the middle of a clear
        next_cycle();
        write_reg(4'd9, 24'h5A5A5A);
        clr_req = 1'b1;
        next_cycle();
        clr_req = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cycles++;
            if (busy_cycles == 5) break;
        end
        check("arst_reached_cycle5", busy_cycles, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy_now", busy, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        set_ra(4'd9, 4'd11);
        @(negedge clk);
        check("arst_busy_after", busy, 1'b0);
        check("arst_rd9", rd[23:0], 24'h0);
        check("arst_rd11", rd[47:24], 24'h0);
        next_cycle();
        write_reg(4'd2, 24'hC0FFEE);
        set_ra(4'd2, 4'd9);
        @(negedge clk);
        check("arst_idle_write", rd[23:0], 24'hC0FFEE);
        check("arst_idle_no_err", wr_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
